scpu_io_port: RTL and testbench

SCPU_IO_PORT -- requirements
Module: scpu_io_port

---
 rtl/scpu_io_port.sv | 155 +++++++++++++++
 tb/tb_scpu_io_port.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scpu_io_port.sv
// scpu_io_port: CPU-facing I/O block with one holding register per external
// input channel (capture-once, drop-while-full) and an output FIFO written
// by the CPU and drained by an external consumer.
// Optional feature: define SCPU_IO_OVF_CNT_EN to build the saturating
// dropped-sample counter on ovf_cnt; otherwise ovf_cnt is tied to zero.
module scpu_io_port #(
    parameter int DATA_W     = 8,
    parameter int IN_CH      = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (IN_CH > 1) ? $clog2(IN_CH) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_CH*DATA_W-1:0] ext_in,
    input  logic [IN_CH-1:0]        ext_in_valid,
    input  logic                    cpu_rd,
    input  logic                    cpu_wr,
    input  logic [CH_W-1:0]         cpu_sel,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_stall,
    output logic [DATA_W-1:0]       ext_out,
    output logic                    ext_out_valid,
    input  logic                    ext_out_ready,
    output logic [IN_CH-1:0]        in_pending,
    output logic [CNT_W-1:0]        fifo_count,
    output logic [7:0]              ovf_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [IN_CH-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0] hold_q [IN_CH];
    logic [DATA_W-1:0] hold_d [IN_CH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic [IN_CH-1:0]  sel_oh;
    logic [IN_CH-1:0]  rd_hit;
    logic              sel_pend;
    logic [DATA_W-1:0] sel_word;
    logic              full, empty;
    logic              rd_fire, wr_fire, pop;

    // Decode the CPU channel select; out-of-range selects match no channel
    always_comb begin
        sel_oh   = '0;
        sel_pend = 1'b0;
        sel_word = '0;
        for (int i = 0; i < IN_CH; i++) begin
            if (cpu_sel == CH_W'(i)) begin
                sel_oh[i] = 1'b1;
                sel_pend  = pend_q[i];
                sel_word  = hold_q[i];
            end
        end
    end

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign cpu_stall = (cpu_rd & ~sel_pend) | (cpu_wr & full);
    assign rd_fire   = cpu_rd & ~cpu_stall;
    assign wr_fire   = cpu_wr & ~cpu_stall;
    assign pop       = ~empty & ext_out_ready;
    assign rd_hit    = sel_oh & {IN_CH{rd_fire}};

    // Holding registers: a completing read frees the slot in the same cycle,
    // so a sample arriving alongside it is captured rather than dropped
    always_comb begin
        pend_d  = pend_q;
        hold_d  = hold_q;
        rdata_d = rd_fire ? sel_word : rdata_q;
        for (int i = 0; i < IN_CH; i++) begin
            if (ext_in_valid[i] && (!pend_q[i] || rd_hit[i])) begin
                hold_d[i] = ext_in[i*DATA_W +: DATA_W];
                pend_d[i] = 1'b1;
            end else if (rd_hit[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; full is taken from the registered count
    always_comb begin
        rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = wr_fire ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({wr_fire, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and data state, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q   <= '0;
            rdata_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < IN_CH; i++) hold_q[i] <= '0;
        end else begin
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // FIFO storage is left unreset; an empty FIFO never exposes it
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= cpu_wdata;
    end

    assign cpu_rdata     = rdata_q;
    assign ext_out       = empty ? '0 : mem[rd_ptr_q];
    assign ext_out_valid = ~empty;
    assign in_pending    = pend_q;
    assign fifo_count    = count_q;

`ifdef SCPU_IO_OVF_CNT_EN
    logic [4:0] drops;
    logic [8:0] ovf_sum;
    logic [7:0] ovf_q, ovf_d;

    // Count samples dropped this cycle across all channels and saturate at 255
    always_comb begin
        drops = '0;
        for (int i = 0; i < IN_CH; i++) begin
            drops = drops + 5'(ext_in_valid[i] & pend_q[i] & ~rd_hit[i]);
        end
        ovf_sum = {1'b0, ovf_q} + 9'(drops);
        ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end

    // Overflow counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf_q <= '0;
        else      ovf_q <= ovf_d;
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_scpu_io_port.sv
// Testbench for scpu_io_port: directed scenarios plus a randomized phase,
// checked each cycle against a queue/array reference model.
module tb_scpu_io_port;

    localparam int DW  = 8;
    localparam int NCH = 4;
    localparam int DEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NCH*DW-1:0] ext_in;
    logic [NCH-1:0]    ext_in_valid;
    logic              cpu_rd, cpu_wr, ext_out_ready;
    logic [1:0]        cpu_sel;
    logic [7:0]        cpu_wdata;
    wire  [7:0]        cpu_rdata, ext_out, ovf_cnt;
    wire               cpu_stall, ext_out_valid;
    wire  [3:0]        in_pending;
    wire  [2:0]        fifo_count;

    // second instance: two-entry FIFO
    logic              wr2, ready2;
    logic [7:0]        wdata2;
    wire  [7:0]        rdata2, ext_out2, ovf2;
    wire               stall2, valid2;
    wire  [3:0]        pend2;
    wire  [1:0]        count2;

    scpu_io_port #(.DATA_W(DW), .IN_CH(NCH), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .ext_in(ext_in), .ext_in_valid(ext_in_valid),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .ext_out(ext_out),
        .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .in_pending(in_pending), .fifo_count(fifo_count), .ovf_cnt(ovf_cnt)
    );

    scpu_io_port #(.DATA_W(DW), .IN_CH(NCH), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .ext_in('0), .ext_in_valid('0),
        .cpu_rd(1'b0), .cpu_wr(wr2), .cpu_sel(2'd0), .cpu_wdata(wdata2),
        .cpu_rdata(rdata2), .cpu_stall(stall2), .ext_out(ext_out2),
        .ext_out_valid(valid2), .ext_out_ready(ready2),
        .in_pending(pend2), .fifo_count(count2), .ovf_cnt(ovf2)
    );

    // reference model state
    bit [7:0] hold_m [NCH];
    bit       pend_m [NCH];
    bit [7:0] rdata_m;
    bit [7:0] q_m [$];
    bit [7:0] q2_m [$];
    int       ovf_m;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit exp_stall();
        return (cpu_rd && !pend_m[cpu_sel]) || (cpu_wr && q_m.size() == DEP);
    endfunction

    function automatic bit exp_stall2();
        return wr2 && q2_m.size() == 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            hold_m[i] = '0;
            pend_m[i] = 1'b0;
        end
        rdata_m = '0;
        q_m.delete();
        q2_m.delete();
        ovf_m = 0;
    endtask

    // Apply one clock edge to the model using the inputs presented to the DUT
    task automatic model_edge();
        bit st    = exp_stall();
        bit st2   = exp_stall2();
        bit popq  = (q_m.size() > 0) && ext_out_ready;
        bit pop2  = (q2_m.size() > 0) && ready2;
        int drops = 0;
        if (cpu_rd && !st) begin
            rdata_m         = hold_m[cpu_sel];
            pend_m[cpu_sel] = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            if (ext_in_valid[i]) begin
                if (pend_m[i]) drops++;
                else begin
                    hold_m[i] = ext_in[i*DW +: DW];
                    pend_m[i] = 1'b1;
                end
            end
        end
        if (popq) void'(q_m.pop_front());
        if (cpu_wr && !st) q_m.push_back(cpu_wdata);
        if (pop2) void'(q2_m.pop_front());
        if (wr2 && !st2) q2_m.push_back(wdata2);
        ovf_m = (ovf_m + drops > 255) ? 255 : ovf_m + drops;
    endtask

    task automatic check_outputs();
        logic [3:0] p;
        int         eovf;
        for (int i = 0; i < NCH; i++) p[i] = pend_m[i];
`ifdef SCPU_IO_OVF_CNT_EN
        eovf = ovf_m;
`else
        eovf = 0;
`endif
        chk("rdata", cpu_rdata, rdata_m);
        chk("pending", in_pending, p);
        chk("count", fifo_count, q_m.size());
        chk("out_valid", ext_out_valid, q_m.size() > 0);
        chk("ext_out", ext_out, (q_m.size() > 0) ? q_m[0] : 8'h00);
        chk("ovf", ovf_cnt, eovf);
        chk("count2", count2, q2_m.size());
        chk("valid2", valid2, q2_m.size() > 0);
        chk("ext_out2", ext_out2, (q2_m.size() > 0) ? q2_m[0] : 8'h00);
    endtask

    // One clock: check combinational stall, take the edge, check state
    task automatic cycle();
        #1;
        chk("stall", cpu_stall, exp_stall());
        chk("stall2", stall2, exp_stall2());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        ext_in        = '0;
        ext_in_valid  = '0;
        cpu_rd        = 1'b0;
        cpu_wr        = 1'b0;
        cpu_sel       = '0;
        cpu_wdata     = '0;
        ext_out_ready = 1'b0;
        wr2           = 1'b0;
        wdata2        = '0;
        ready2        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("reset_stall", cpu_stall, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] v);
        ext_in[ch*DW +: DW] = v;
    endtask

    initial begin
        do_reset();

        // single capture then read on channel 0
        set_ch(0, 8'h0f);
        ext_in_valid = 4'b0001;
        cycle();
        ext_in_valid = '0;
        cpu_rd = 1'b1;
        cpu_sel = 2'd0;
        #1;
        chk("r037_stall", cpu_stall, 1'b0);
        cycle();
        cpu_rd = 1'b0;
        chk("r037_rdata", cpu_rdata, 8'h0f);
        chk("r037_pend0", in_pending[0], 1'b0);

        // read of an empty channel stalls until a sample arrives
        cpu_rd = 1'b1;
        cpu_sel = 2'd2;
        repeat (3) cycle();
        chk("r038_stall_wait", cpu_stall, 1'b1);
        set_ch(2, 8'hA5);
        ext_in_valid = 4'b0100;
        cycle();
        ext_in_valid = '0;
        #1;
        chk("r038_stall_clear", cpu_stall, 1'b0);
        cycle();
        cpu_rd = 1'b0;
        chk("r038_rdata", cpu_rdata, 8'hA5);

        // fill the FIFO, fifth write stalls, drain in order
        ext_out_ready = 1'b0;
        cpu_wr = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cpu_wdata = 8'(k);
            cycle();
        end
        cpu_wdata = 8'h05;
        cycle();
        chk("r039_count_full", fifo_count, 3'd4);
        chk("r039_stall_full", cpu_stall, 1'b1);
        ext_out_ready = 1'b1;
        chk("r039_head1", ext_out, 8'h01);
        cycle();
        chk("r039_head2", ext_out, 8'h02);
        chk("r039_count_pop", fifo_count, 3'd3);
        cycle();
        chk("r039_head3", ext_out, 8'h03);
        chk("r039_count_pushpop", fifo_count, 3'd3);
        cpu_wr = 1'b0;
        cycle();
        chk("r039_head4", ext_out, 8'h04);
        cycle();
        chk("r039_head5", ext_out, 8'h05);
        cycle();
        chk("r039_empty_valid", ext_out_valid, 1'b0);
        chk("r039_empty_out", ext_out, 8'h00);

        // drops while pending; the read returns the first sample
        do_reset();
        ext_in_valid = 4'b0010;
        set_ch(1, 8'h11);
        cycle();
        set_ch(1, 8'h22);
        cycle();
        set_ch(1, 8'h33);
        cycle();
        ext_in_valid = '0;
        cpu_rd = 1'b1;
        cpu_sel = 2'd1;
        cycle();
        cpu_rd = 1'b0;
        chk("r040_rdata", cpu_rdata, 8'h11);
`ifdef SCPU_IO_OVF_CNT_EN
        chk("r040_ovf", ovf_cnt, 8'd2);
`else
        chk("r040_ovf", ovf_cnt, 8'd0);
`endif

        // read plus new sample on the same channel in one cycle: no drop
        set_ch(3, 8'h44);
        ext_in_valid = 4'b1000;
        cycle();
        set_ch(3, 8'h55);
        cpu_rd = 1'b1;
        cpu_sel = 2'd3;
        cycle();
        ext_in_valid = '0;
        cpu_rd = 1'b0;
        chk("r026_rdata", cpu_rdata, 8'h44);
        chk("r026_pend3", in_pending[3], 1'b1);

        // two-entry FIFO: push+pop with one entry, across pointer wrap
        ready2 = 1'b0;
        wr2 = 1'b1;
        wdata2 = 8'hAA;
        cycle();
        ready2 = 1'b1;
        wdata2 = 8'h7E;
        cycle();
        chk("r041_count_pp", count2, 2'd1);
        chk("r041_head_7e", ext_out2, 8'h7E);
        for (int k = 0; k < 3; k++) begin
            wdata2 = 8'h81 + 8'(k);
            cycle();
            chk("r041_head_wrap", ext_out2, 8'h81 + 8'(k));
        end
        ready2 = 1'b0;
        wdata2 = 8'h90;
        cycle();
        chk("r041_count_full", count2, 2'd2);
        ready2 = 1'b1;
        wdata2 = 8'h91;
        #1;
        chk("r041_stall_full", stall2, 1'b1);
        cycle();
        chk("r041_count_popfull", count2, 2'd1);
        chk("r041_head_90", ext_out2, 8'h90);
        cycle();
        chk("r041_head_91", ext_out2, 8'h91);
        wr2 = 1'b0;
        cycle();
        chk("r041_empty", count2, 2'd0);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ext_in        = $urandom;
            ext_in_valid  = 4'($urandom & $urandom);
            cpu_rd        = 1'($urandom);
            cpu_sel       = 2'($urandom);
            cpu_wr        = 1'($urandom);
            cpu_wdata     = 8'($urandom);
            ext_out_ready = ($urandom_range(0, 2) == 0);
            wr2           = 1'($urandom);
            wdata2        = 8'($urandom);
            ready2        = 1'($urandom);
            cycle();
        end

        // asynchronous reset mid-burst
        do_reset();
        set_ch(0, 8'h3C);
        ext_in_valid = 4'b0001;
        cpu_wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cpu_wdata = 8'hC0 + 8'(k);
            cycle();
            ext_in_valid = '0;
        end
        chk("r042_count_pre", fifo_count, 3'd3);
        chk("r042_pend_pre", in_pending[0], 1'b1);
        rst = 1'b0;
        #2;
        chk("r042_valid", ext_out_valid, 1'b0);
        chk("r042_count", fifo_count, 3'd0);
        chk("r042_pending", in_pending, 4'b0000);
        chk("r042_ext_out", ext_out, 8'h00);
        model_reset();
        idle();
        @(negedge clk);
        rst = 1'b1;
        ext_out_ready = 1'b1;
        cycle();
        cycle();
        chk("r042_after", fifo_count, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
